// File: rtl/voice_bank_if.sv
// Sample ROM read port shared by all voices of voice_bank.
// master: mem_en/mem_addr out, mem_data in (1-cycle latency).
interface voice_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/voice_bank.sv
// Multi-voice sample playback: voices time-share one ROM port, one mix word per sample_tick.
// Ports: clk, rst_n, sample_tick, trigger, sstart/send/step (packed per voice), mem (ROM bus),
// mix_out, mix_valid, active, overrun. Define VOICE_BANK_LOOP_EN to add the `loop` input.
module voice_bank #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int NUM_VOICES = 4,
  parameter int FRAC_W     = 4,
  parameter int STEP_W     = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sample_tick,
  input  logic [NUM_VOICES-1:0]            trigger,
  input  logic [NUM_VOICES*ADDR_W-1:0]     sstart,
  input  logic [NUM_VOICES*ADDR_W-1:0]     send,
  input  logic [NUM_VOICES*STEP_W-1:0]     step,
`ifdef VOICE_BANK_LOOP_EN
  input  logic [NUM_VOICES-1:0]            loop,
`endif
  voice_bank_if.master                     mem,
  output logic [DATA_W+$clog2(NUM_VOICES+1)-1:0] mix_out,
  output logic                             mix_valid,
  output logic [NUM_VOICES-1:0]            active,
  output logic                             overrun
);

  localparam int MIX_W = DATA_W + $clog2(NUM_VOICES + 1);
  localparam int PW    = ADDR_W + FRAC_W;
  localparam int CW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_VOICES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  rd_q;
  logic [MIX_W-1:0]      acc_q;
  logic [MIX_W-1:0]      mix_q;
  logic                  mixv_q;
  logic                  ovr_q;
  logic [NUM_VOICES-1:0] trig_q, trig_qq;
  logic [NUM_VOICES-1:0] act_q;
  logic [PW-1:0]         pos_q [NUM_VOICES];

  logic [NUM_VOICES-1:0] trig_edge;
  logic [NUM_VOICES-1:0] loop_w;
  logic [NUM_VOICES-1:0] done;
  logic [PW:0]           sum [NUM_VOICES];
  logic                  fetch_en;
  logic [ADDR_W-1:0]     fetch_addr;

`ifdef VOICE_BANK_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = '0;
`endif

  assign trig_edge = trig_q & ~trig_qq;

  // One spare MSB catches address wrap past the top of the ROM.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum[i]  = {1'b0, pos_q[i]}
              + {{(PW + 1 - STEP_W){1'b0}}, step[i*STEP_W +: STEP_W]};
      done[i] = sum[i][PW]
              | (sum[i][PW-1:FRAC_W] > send[i*ADDR_W +: ADDR_W]);
    end
  end

  // Idle/inactive slots keep the last address on the bus.
  always_comb begin
    fetch_en   = (state_q == S_FETCH) && act_q[cnt_q];
    fetch_addr = addr_q;
    if (fetch_en) fetch_addr = pos_q[cnt_q][PW-1:FRAC_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == LAST) state_d = S_DRAIN;
        else cnt_d = cnt_q + CW'(1);
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      acc_q   <= '0;
      mix_q   <= '0;
      mixv_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= fetch_addr;
      rd_q    <= fetch_en;
      ovr_q   <= sample_tick && (state_q != S_IDLE);
      mixv_q  <= (state_q == S_DRAIN);
      if (state_q == S_IDLE && sample_tick) acc_q <= '0;
      else if (rd_q) acc_q <= acc_q + MIX_W'(mem.mem_data);
      // Last slot's data lands in DRAIN; fold it straight into the output.
      if (state_q == S_DRAIN)
        mix_q <= acc_q + (rd_q ? MIX_W'(mem.mem_data) : '0);
    end
  end

  // Restart has priority over an advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= '0;
      trig_qq <= '0;
      act_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) pos_q[i] <= '0;
    end else begin
      trig_q  <= trigger;
      trig_qq <= trig_q;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (trig_edge[i]) begin
          pos_q[i] <= {sstart[i*ADDR_W +: ADDR_W], {FRAC_W{1'b0}}};
          act_q[i] <= 1'b1;
        end else if (state_q == S_FETCH && cnt_q == CW'(i) && act_q[i]) begin
          if (!done[i])
            pos_q[i] <= sum[i][PW-1:0];
          else if (loop_w[i])
            pos_q[i] <= {sstart[i*ADDR_W +: ADDR_W], {FRAC_W{1'b0}}};
          else
            act_q[i] <= 1'b0;
        end
      end
    end
  end

  assign mem.mem_en   = fetch_en;
  assign mem.mem_addr = fetch_addr;
  assign mix_out      = mix_q;
  assign mix_valid    = mixv_q;
  assign active       = act_q;
  assign overrun      = ovr_q;

endmodule
